alu_seq_param: RTL

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_seq_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpAsr = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;
  localparam logic [3:0] OpMul = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one conditional add and right shift per enabled cycle.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     partial;

  // Upper half plus multiplicand when the current multiplier LSB is set; keeps the carry.
  always_comb begin
    partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      partial = partial + {1'b0, mcand_q};
    end
  end

  assign done    = busy_q && (cnt_q == CntW'(WIDTH));
  assign prod_lo = prod_q[WIDTH-1:0];
  assign prod_hi = prod_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      if (start) begin
        prod_q  <= {{WIDTH{1'b0}}, b};
        mcand_q <= a;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (done) begin
        busy_q <= 1'b0;
      end else if (busy_q) begin
        prod_q <= {partial, prod_q[WIDTH-1:1]};
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU with valid/ready handshakes, an accumulator operand and an iterative MUL.
// Opcode width must be at least 4 so every defined opcode is representable.
module alu_seq_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = alu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_err
);

  import alu_pkg::*;

  localparam int unsigned Msb = WIDTH - 1;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  flags_t           flags_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic             in_is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] a_sel;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_r;
  flags_t           alu_f;
  flags_t           mul_f;

  assign accept    = ena && in_valid && in_ready_q;
  assign in_is_mul = (op == OP_W'(OpMul));
  assign mul_start = accept && in_is_mul;
  assign a_sel     = use_acc ? acc_q : a;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (mul_start),
    .a      (a_sel),
    .b      (b),
    .done   (mul_done),
    .prod_lo(mul_lo),
    .prod_hi(mul_hi)
  );

  // Single-cycle datapath, evaluated from the operands captured at accept.
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    alu_r = '0;
    alu_f = '0;
    // MUL never reaches EXEC, so anything at or above its code is illegal here.
    if (op_q >= OP_W'(OpMul)) begin
      alu_f.err = 1'b1;
    end else begin
      unique case (op_q[3:0])
        OpAdd: begin
          alu_r   = sum[WIDTH-1:0];
          alu_f.c = sum[WIDTH];
          alu_f.v = (a_q[Msb] == b_q[Msb]) && (alu_r[Msb] != a_q[Msb]);
        end
        OpSub, OpCmp: begin
          alu_r   = diff[WIDTH-1:0];
          alu_f.c = diff[WIDTH];
          alu_f.v = (a_q[Msb] != b_q[Msb]) && (alu_r[Msb] != a_q[Msb]);
        end
        OpAnd: alu_r = a_q & b_q;
        OpOr:  alu_r = a_q | b_q;
        OpXor: alu_r = a_q ^ b_q;
        OpNot: alu_r = ~a_q;
        OpShl: begin
          alu_r   = {a_q[WIDTH-2:0], 1'b0};
          alu_f.c = a_q[Msb];
        end
        OpShr: begin
          alu_r   = {1'b0, a_q[WIDTH-1:1]};
          alu_f.c = a_q[0];
        end
        OpAsr: begin
          alu_r   = {a_q[Msb], a_q[WIDTH-1:1]};
          alu_f.c = a_q[0];
        end
        default: alu_r = '0;
      endcase
      alu_f.z = (alu_r == '0);
      alu_f.n = alu_r[Msb];
      // CMP reports the flags of a-b but passes a through unchanged.
      if (op_q[3:0] == OpCmp) begin
        alu_r = a_q;
      end
    end
  end

  always_comb begin
    mul_f   = '0;
    mul_f.z = (mul_lo == '0);
    mul_f.n = mul_lo[Msb];
    mul_f.v = (mul_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a_sel;
            b_q        <= b;
            op_q       <= op;
            in_ready_q <= 1'b0;
            state_q    <= in_is_mul ? StMul : StExec;
          end
        end
        StExec: begin
          result_q    <= alu_r;
          result_hi_q <= '0;
          flags_q     <= alu_f;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StMul: begin
          if (mul_done) begin
            result_q    <= mul_lo;
            result_hi_q <= mul_hi;
            flags_q     <= mul_f;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            acc_q       <= result_q;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;
  assign flag_err  = flags_q.err;

endmodule
